pc_gen: RTL and testbench

- Parametrised program-counter generator for the fetch stage; successor to the single-register PC.
- Holds the fetch PC and selects the next PC from trap, redirect and sequential sources, with stall support.
- Adds a valid/ready fetch handshake, a boot/run/halt state machine, misaligned-redirect detection and a fetch counter.
- Sits between the next-PC control (branch unit, trap logic, debug halt) and the instruction memory port.

---
 rtl/pc_gen.sv | 101 ++++++++++
 tb/tb_pc_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program counter: trap/redirect/sequential next-PC selection,
// valid/ready fetch handshake, boot/run/halt control and misaligned-redirect faulting.
module pc_gen #(
    parameter int unsigned           XLEN         = 32,
    parameter logic [XLEN-1:0]       RESET_VECTOR = XLEN'(32'h8000_0000),
    parameter logic [XLEN-1:0]       TRAP_VECTOR  = XLEN'(32'h8000_0100),
    parameter int unsigned           IALIGN_BYTES = 4,
    parameter int unsigned           CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_target,
    input  logic             halt_req,
    output logic [XLEN-1:0]  PC,
    output logic [XLEN-1:0]  PCPlus4,
    output logic             fetch_valid,
    output logic             halted,
    output logic             misalign_fault,
    output logic [XLEN-1:0]  fault_addr,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN_BYTES - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  fault_addr_q, fault_addr_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             redirect_misaligned;

    assign fetch_valid         = (state_q == ST_RUN);
    assign halted              = (state_q == ST_HALTED);
    assign accept              = fetch_valid & fetch_ready & ~stall;
    assign redirect_misaligned = ((redirect_target & ALIGN_MASK) != '0);

    // Next-state and next-PC selection; BOOT holds the PC for its single cycle.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_addr_d = fault_addr_q;
        misalign_d   = 1'b0;
        cnt_d        = cnt_q;

        if (state_q != ST_BOOT) begin
            if (trap_valid) begin
                pc_d = trap_target;
            end else if (redirect_valid) begin
                if (redirect_misaligned) begin
                    pc_d         = TRAP_VECTOR;
                    misalign_d   = 1'b1;
                    fault_addr_d = redirect_target;
                end else begin
                    pc_d = redirect_target;
                end
            end else if (accept) begin
                pc_d  = pc_q + PC_STEP;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Every state leaves toward HALTED or RUN purely on the halt level.
        state_d = halt_req ? ST_HALTED : ST_RUN;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            fault_addr_q <= '0;
            misalign_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fault_addr_q <= fault_addr_d;
            misalign_q   <= misalign_d;
            cnt_q        <= cnt_d;
        end
    end

    assign PC             = pc_q;
    assign PCPlus4        = pc_q + PC_STEP;
    assign misalign_fault = misalign_q;
    assign fault_addr     = fault_addr_q;
    assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a default instance and a compressed-ISA,
// narrow-counter, wrap-vector instance share stimulus and a behavioural model.
module tb_pc_gen;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_target = 32'h0;
    logic        halt_req = 1'b0;

    logic [31:0] d0_pc, d0_p4, d0_fa, d0_cnt;
    logic        d0_fv, d0_h, d0_f;
    logic [31:0] d1_pc, d1_p4, d1_fa;
    logic [1:0]  d1_cnt;
    logic        d1_fv, d1_h, d1_f;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    pc_gen u_dut0 (
        .CLK(CLK), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_target(trap_target), .halt_req(halt_req),
        .PC(d0_pc), .PCPlus4(d0_p4), .fetch_valid(d0_fv), .halted(d0_h),
        .misalign_fault(d0_f), .fault_addr(d0_fa), .fetch_count(d0_cnt)
    );

    pc_gen #(
        .RESET_VECTOR(32'hFFFF_FFFC), .IALIGN_BYTES(2), .CNT_W(2)
    ) u_dut1 (
        .CLK(CLK), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_target(trap_target), .halt_req(halt_req),
        .PC(d1_pc), .PCPlus4(d1_p4), .fetch_valid(d1_fv), .halted(d1_h),
        .misalign_fault(d1_f), .fault_addr(d1_fa), .fetch_count(d1_cnt)
    );

    // Reference model: one entry per instance, stepped from the behavioural rules.
    localparam bit [31:0] TRAP_VEC = 32'h8000_0100;
    bit [31:0] p_rv[2]    = '{32'h8000_0000, 32'hFFFF_FFFC};
    int        p_align[2] = '{4, 2};
    longint    p_mod[2]   = '{64'h1_0000_0000, 64'd4};

    bit [31:0] m_pc[2];
    string     m_mode[2];
    bit        m_fault[2];
    bit [31:0] m_faddr[2];
    longint    m_cnt[2];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] p4;
        logic        fv;
        logic        h;
        logic        f;
        logic [31:0] fa;
        logic [31:0] cnt;
    } obs_t;

    function automatic obs_t observe(input int k);
        obs_t o;
        if (k == 0) begin
            o.pc = d0_pc; o.p4 = d0_p4; o.fv = d0_fv; o.h = d0_h;
            o.f = d0_f; o.fa = d0_fa; o.cnt = d0_cnt;
        end else begin
            o.pc = d1_pc; o.p4 = d1_p4; o.fv = d1_fv; o.h = d1_h;
            o.f = d1_f; o.fa = d1_fa; o.cnt = 32'(d1_cnt);
        end
        return o;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_pc[k] = p_rv[k]; m_mode[k] = "BOOT"; m_fault[k] = 1'b0;
                m_faddr[k] = 32'h0; m_cnt[k] = 0;
            end else begin
                m_fault[k] = 1'b0;
                if (m_mode[k] != "BOOT") begin
                    if (trap_valid) begin
                        m_pc[k] = trap_target;
                    end else if (redirect_valid) begin
                        if ((redirect_target % p_align[k]) != 0) begin
                            m_pc[k] = TRAP_VEC; m_fault[k] = 1'b1; m_faddr[k] = redirect_target;
                        end else begin
                            m_pc[k] = redirect_target;
                        end
                    end else if (m_mode[k] == "RUN" && fetch_ready && !stall) begin
                        m_pc[k]  = m_pc[k] + 32'd4;
                        m_cnt[k] = (m_cnt[k] + 1) % p_mod[k];
                    end
                end
                m_mode[k] = halt_req ? "HALTED" : "RUN";
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        total++; if (d0_pc !== 32'h8000_0000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", d0_pc, 32'h8000_0000); end
        total++; if (d0_fv !== 1'b0 || d0_h !== 1'b0) begin bad++; $display("FAIL reset_state got fv=%b h=%b exp fv=0 h=0", d0_fv, d0_h); end
        total++; if (d0_cnt !== 32'h0 || d0_f !== 1'b0 || d0_fa !== 32'h0) begin bad++; $display("FAIL reset_regs got cnt=%h f=%b fa=%h exp 0", d0_cnt, d0_f, d0_fa); end
        total++; if (d1_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL reset_pc_alt got=%h exp=%h", d1_pc, 32'hFFFF_FFFC); end
        reset = 1'b0; fetch_ready = 1'b1;
        tick();
        total++; if (d0_pc !== 32'h8000_0000 || d0_fv !== 1'b1) begin bad++; $display("FAIL boot_exit got pc=%h fv=%b exp pc=80000000 fv=1", d0_pc, d0_fv); end
        tick();
        total++; if (d0_pc !== 32'h8000_0004 || d0_p4 !== 32'h8000_0008) begin bad++; $display("FAIL step1 got pc=%h p4=%h exp 80000004/80000008", d0_pc, d0_p4); end
        tick();
        total++; if (d0_pc !== 32'h8000_0008 || d0_cnt !== 32'd2) begin bad++; $display("FAIL step2 got pc=%h cnt=%0d exp 80000008/2", d0_pc, d0_cnt); end
    endtask

    task automatic test_stall();
        tick(); tick();
        total++; if (d0_pc !== 32'h8000_0010) begin bad++; $display("FAIL stall_pre got=%h exp=%h", d0_pc, 32'h8000_0010); end
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin stall = 1'b0; fetch_ready = 1'b0; end
            tick();
            total++; if (d0_pc !== 32'h8000_0010 || d0_cnt !== 32'd4) begin bad++; $display("FAIL stall_hold[%0d] got pc=%h cnt=%0d exp 80000010/4", i, d0_pc, d0_cnt); end
        end
        fetch_ready = 1'b1;
        tick();
        total++; if (d0_pc !== 32'h8000_0014 || d0_cnt !== 32'd5) begin bad++; $display("FAIL stall_release got pc=%h cnt=%0d exp 80000014/5", d0_pc, d0_cnt); end
    endtask

    task automatic test_priority();
        trap_valid = 1'b1; trap_target = 32'h8000_0200;
        redirect_valid = 1'b1; redirect_target = 32'h8000_0040; stall = 1'b1;
        tick();
        total++; if (d0_pc !== 32'h8000_0200 || d0_f !== 1'b0 || d0_cnt !== 32'd5) begin bad++; $display("FAIL trap_prio got pc=%h f=%b cnt=%0d exp 80000200/0/5", d0_pc, d0_f, d0_cnt); end
        trap_valid = 1'b0; stall = 1'b0;
        tick();
        total++; if (d0_pc !== 32'h8000_0040 || d0_cnt !== 32'd5) begin bad++; $display("FAIL redirect got pc=%h cnt=%0d exp 80000040/5", d0_pc, d0_cnt); end
        redirect_valid = 1'b0;
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_target = 32'h8000_0042;
        tick();
        total++; if (d0_pc !== 32'h8000_0100 || d0_f !== 1'b1 || d0_fa !== 32'h8000_0042) begin bad++; $display("FAIL misalign4 got pc=%h f=%b fa=%h exp 80000100/1/80000042", d0_pc, d0_f, d0_fa); end
        total++; if (d1_pc !== 32'h8000_0042 || d1_f !== 1'b0) begin bad++; $display("FAIL align2 got pc=%h f=%b exp 80000042/0", d1_pc, d1_f); end
        redirect_valid = 1'b0; fetch_ready = 1'b0;
        tick();
        total++; if (d0_f !== 1'b0 || d0_fa !== 32'h8000_0042) begin bad++; $display("FAIL fault_pulse got f=%b fa=%h exp 0/80000042", d0_f, d0_fa); end
        redirect_valid = 1'b1; redirect_target = 32'h8000_0001;
        tick();
        redirect_target = 32'h8000_0003;
        tick();
        total++; if (d0_f !== 1'b1 || d0_fa !== 32'h8000_0003) begin bad++; $display("FAIL b2b_fault got f=%b fa=%h exp 1/80000003", d0_f, d0_fa); end
        total++; if (d1_f !== 1'b1 || d1_fa !== 32'h8000_0003 || d1_pc !== 32'h8000_0100) begin bad++; $display("FAIL b2b_fault_alt got f=%b fa=%h pc=%h exp 1/80000003/80000100", d1_f, d1_fa, d1_pc); end
        redirect_valid = 1'b0;
    endtask

    task automatic test_halt();
        fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h8000_0020;
        tick();
        redirect_valid = 1'b0; halt_req = 1'b1;
        tick();
        total++; if (d0_pc !== 32'h8000_0024 || d0_h !== 1'b1 || d0_fv !== 1'b0) begin bad++; $display("FAIL halt_enter got pc=%h h=%b fv=%b exp 80000024/1/0", d0_pc, d0_h, d0_fv); end
        total++; if (d0_cnt !== 32'(m_cnt[0])) begin bad++; $display("FAIL halt_count got=%0d exp=%0d", d0_cnt, m_cnt[0]); end
        redirect_valid = 1'b1; redirect_target = 32'h8000_0080;
        tick();
        total++; if (d0_pc !== 32'h8000_0080 || d0_h !== 1'b1) begin bad++; $display("FAIL halt_write got pc=%h h=%b exp 80000080/1", d0_pc, d0_h); end
        redirect_valid = 1'b0; halt_req = 1'b0;
        tick();
        total++; if (d0_pc !== 32'h8000_0080 || d0_fv !== 1'b1 || d0_h !== 1'b0) begin bad++; $display("FAIL resume got pc=%h fv=%b h=%b exp 80000080/1/0", d0_pc, d0_fv, d0_h); end
        tick();
        total++; if (d0_pc !== 32'h8000_0084) begin bad++; $display("FAIL resume_fetch got=%h exp=%h", d0_pc, 32'h8000_0084); end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        tick();
        reset = 1'b0; fetch_ready = 1'b1;
        tick();
        tick();
        total++; if (d1_pc !== 32'h0000_0000 || d1_cnt !== 2'd1) begin bad++; $display("FAIL pc_wrap got pc=%h cnt=%0d exp 00000000/1", d1_pc, d1_cnt); end
        tick(); tick(); tick();
        total++; if (d1_cnt !== 2'd0 || d1_pc !== 32'h0000_000C) begin bad++; $display("FAIL cnt_wrap got cnt=%0d pc=%h exp 0/0000000c", d1_cnt, d1_pc); end
        halt_req = 1'b1;
        tick();
        total++; if (d1_h !== 1'b1) begin bad++; $display("FAIL wrap_halt got h=%b exp 1", d1_h); end
        reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h8000_0400;
        tick();
        total++; if (d1_pc !== 32'hFFFF_FFFC || d1_fv !== 1'b0 || d1_h !== 1'b0 || d1_cnt !== 2'd0) begin bad++; $display("FAIL reset_in_halt got pc=%h fv=%b h=%b cnt=%0d exp fffffffc/0/0/0", d1_pc, d1_fv, d1_h, d1_cnt); end
        reset = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    endtask

    task automatic test_random();
        obs_t o;
        bit [31:0] r;
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 39) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            fetch_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 5) == 0);
            r = $urandom;
            redirect_target = ($urandom_range(0, 1) == 0) ? {r[31:2], 2'b00} : r;
            trap_valid     = ($urandom_range(0, 9) == 0);
            trap_target    = $urandom;
            halt_req       = ($urandom_range(0, 7) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                o = observe(k);
                total++; if (o.pc !== m_pc[k]) begin bad++; $display("FAIL rnd_pc[%0d] cyc=%0d got=%h exp=%h", k, i, o.pc, m_pc[k]); end
                total++; if (o.p4 !== m_pc[k] + 32'd4) begin bad++; $display("FAIL rnd_p4[%0d] cyc=%0d got=%h exp=%h", k, i, o.p4, m_pc[k] + 32'd4); end
                total++; if (o.fv !== (m_mode[k] == "RUN") || o.h !== (m_mode[k] == "HALTED")) begin bad++; $display("FAIL rnd_state[%0d] cyc=%0d got fv=%b h=%b exp mode=%s", k, i, o.fv, o.h, m_mode[k]); end
                total++; if (o.f !== m_fault[k] || o.fa !== m_faddr[k]) begin bad++; $display("FAIL rnd_fault[%0d] cyc=%0d got f=%b fa=%h exp f=%b fa=%h", k, i, o.f, o.fa, m_fault[k], m_faddr[k]); end
                total++; if (o.cnt !== 32'(m_cnt[k])) begin bad++; $display("FAIL rnd_cnt[%0d] cyc=%0d got=%0d exp=%0d", k, i, o.cnt, m_cnt[k]); end
            end
        end
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0; halt_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_priority();
        test_misalign();
        test_halt();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
